// File: rtl/div.sv
// ----------------------------------------------------------------------------
// div - sequential 4-bit unsigned restoring divider.
//
// Releasing reset starts one division. The first edge after release samples
// x/y (LOAD). Four shift/subtract iterations follow, and then q/r are
// presented with done=1. A zero divisor is reported as error=1, done=1.
// The block then holds its result until reset is asserted again.
//
// Ports:
//   clock  in   rising-edge system clock
//   reset  in   async active-low; low clears/holds, release starts a division
//   x      in   [3:0] dividend (unsigned), sampled in LOAD only
//   y      in   [3:0] divisor  (unsigned), sampled in LOAD only
//   q      out  [3:0] quotient, valid when done=1
//   r      out  [3:0] remainder, valid when done=1
//   error  out  divide-by-zero flag
//   done   out  result valid / operation finished
// ----------------------------------------------------------------------------
module div (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       error,
    output logic       done
);

    typedef enum logic [2:0] {LOAD, SHIFT, SUB, DONE, ERR} state_t;

    state_t     state;
    // data[8:4]: partial remainder. The 5th bit absorbs the shift overflow,
    // so the maximum value is 2*14+1 = 29.
    // data[3:0]: dividend bits, replaced by quotient bits as they shift out.
    logic [8:0] data;
    logic [3:0] dvsr;
    logic [2:0] count;

    // Trial subtraction for the SUB step.
    logic       sub_ge;
    logic [8:0] sub_data;

    always_comb begin
        sub_ge   = (data[8:4] >= {1'b0, dvsr});
        sub_data = data;
        if (sub_ge) begin
            sub_data[8:4] = data[8:4] - {1'b0, dvsr};
            sub_data[0]   = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            data  <= '0;
            dvsr  <= '0;
            count <= '0;
            q     <= '0;
            r     <= '0;
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (y == 4'd0) begin
                        state <= ERR;
                    end else begin
                        dvsr  <= y;
                        data  <= {5'b0, x};
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    data  <= {data[7:0], 1'b0};
                    state <= SUB;
                end
                SUB: begin
                    data  <= sub_data;
                    count <= count + 3'd1;
                    // count is about to become 4: this is the last iteration,
                    // so publish the post-subtract values directly.
                    if (count == 3'd3) begin
                        q     <= sub_data[3:0];
                        r     <= sub_data[7:4];
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                ERR: begin
                    error <= 1'b1;
                    done  <= 1'b1;
                    q     <= '0;
                    r     <= '0;
                    state <= ERR;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// ----------------------------------------------------------------------------
// tb_div - directed testbench for div. Each vector carries hand-computed
// quotient/remainder values. All comparisons go through chk().
// ----------------------------------------------------------------------------
module tb_div;

    logic       clock;
    logic       reset;
    logic [3:0] x, y;
    logic [3:0] q, r;
    logic       error, done;

    int checks = 0;
    int errors = 0;

    div dut (
        .clock (clock),
        .reset (reset),
        .x     (x),
        .y     (y),
        .q     (q),
        .r     (r),
        .error (error),
        .done  (done)
    );

    // 10 ns period, 50% duty, starts at 0.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".q"},     {4'b0, q}, 8'd0);
        chk({tag, ".r"},     {4'b0, r}, 8'd0);
        chk({tag, ".done"},  {7'b0, done}, 8'd0);
        chk({tag, ".error"}, {7'b0, error}, 8'd0);
    endtask

    // Assert reset, apply operands, release on a falling edge so that the
    // next rising edge is edge 1 (LOAD).
    task automatic start(input logic [3:0] xv, input logic [3:0] yv, input string tag);
        reset = 1'b0;
        x     = xv;
        y     = yv;
        #2;
        chk_zero({tag, ".rst"});
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_div(input logic [3:0] xv, input logic [3:0] yv,
                           input logic [3:0] eq, input logic [3:0] er, input string tag);
        start(xv, yv, tag);
        repeat (8) @(posedge clock);
        #1;
        chk({tag, ".busy.done"}, {7'b0, done}, 8'd0);
        chk({tag, ".busy.q"},    {4'b0, q},    8'd0);
        @(posedge clock);
        #1;
        chk({tag, ".q"},     {4'b0, q},     {4'b0, eq});
        chk({tag, ".r"},     {4'b0, r},     {4'b0, er});
        chk({tag, ".done"},  {7'b0, done},  8'd1);
        chk({tag, ".error"}, {7'b0, error}, 8'd0);
        // Result must hold.
        repeat (3) @(posedge clock);
        #1;
        chk({tag, ".hold.q"},    {4'b0, q},    {4'b0, eq});
        chk({tag, ".hold.done"}, {7'b0, done}, 8'd1);
    endtask

    initial begin
        reset = 1'b0;
        x     = 4'd0;
        y     = 4'd0;

        run_div(4'd15, 4'd2,  4'd7,  4'd1, "15/2");
        run_div(4'd7,  4'd3,  4'd2,  4'd1, "7/3");

        // Divide by zero: flags appear after edge 2 and hold.
        start(4'd10, 4'd0, "10/0");
        @(posedge clock);
        #1;
        chk("10/0.e1.error", {7'b0, error}, 8'd0);
        chk("10/0.e1.done",  {7'b0, done},  8'd0);
        @(posedge clock);
        #1;
        chk("10/0.error", {7'b0, error}, 8'd1);
        chk("10/0.done",  {7'b0, done},  8'd1);
        chk("10/0.q",     {4'b0, q},     8'd0);
        chk("10/0.r",     {4'b0, r},     8'd0);
        repeat (10) @(posedge clock);
        #1;
        chk("10/0.hold.error", {7'b0, error}, 8'd1);
        chk("10/0.hold.done",  {7'b0, done},  8'd1);

        run_div(4'd3,  4'd5,  4'd0,  4'd3, "3/5");
        run_div(4'd15, 4'd1,  4'd15, 4'd0, "15/1");
        run_div(4'd15, 4'd15, 4'd1,  4'd0, "15/15");
        run_div(4'd0,  4'd7,  4'd0,  4'd0, "0/7");
        run_div(4'd14, 4'd15, 4'd0,  4'd14, "14/15");

        // Abort a 15/2 run at edge 5, then restart with 9/4.
        start(4'd15, 4'd2, "abort");
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk_zero("abort.mid");
        run_div(4'd9, 4'd4, 4'd2, 4'd1, "9/4");

        // Operand changes after LOAD must be ignored.
        start(4'd15, 4'd2, "late");
        @(posedge clock);
        #1;
        x = 4'd3;
        y = 4'd7;
        repeat (8) @(posedge clock);
        #1;
        chk("late.q",    {4'b0, q},    8'd7);
        chk("late.r",    {4'b0, r},    8'd1);
        chk("late.done", {7'b0, done}, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
